// File: rtl/sprite_desc_loader_if.sv
// Avalon-MM slave bus bundle for the sprite descriptor loader.
// The CPU side is the master; the loader register file is the slave.
interface sprite_desc_loader_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect, write, read, address, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, write, read, address, writedata,
    output readdata
  );
endinterface

// File: rtl/sprite_desc_loader.sv
// Double-buffered sprite descriptors: the CPU writes shadow copies and arms a
// commit, and the active copies are swapped in only at the start of vertical blanking.
//
// state | meaning
// IDLE  | no commit outstanding (pending=0)
// ARMED | commit requested, waits for next vblank_start (pending=1)
module sprite_desc_loader #(
  parameter logic [9:0]  VBLANK_LINE = 10'd480,
  parameter logic [31:0] PARK_DESC   = 32'h000F_FFFF
) (
  input  logic                       clk,
  input  logic                       reset,
  sprite_desc_loader_if.slave        bus,
  input  logic [9:0]                 VGA_VCOUNT,
  output logic [31:0]                sprite1,
  output logic [31:0]                sprite2,
  output logic [31:0]                sprite3,
  output logic                       irq
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] shadow1;
  logic [31:0] shadow2;
  logic [31:0] shadow3;
  logic        irq_en;
  logic        irq_flag;
  logic [15:0] frame_cnt;
  logic [9:0]  vc_q;

  logic        wr_en;
  logic        rd_en;
  logic        wr_ctrl;
  logic        wr_frame;
  logic        vblank_start;
  logic        pending;
  logic [31:0] rd_mux;

  assign wr_en        = bus.chipselect && bus.write;
  assign rd_en        = bus.chipselect && bus.read;
  assign wr_ctrl      = wr_en && (bus.address == 3'd3);
  assign wr_frame     = wr_en && (bus.address == 3'd4);
  assign vblank_start = (VGA_VCOUNT == VBLANK_LINE) && (vc_q != VBLANK_LINE);
  assign pending      = (state == ARMED);
  assign irq          = irq_flag && irq_en;

  always_comb begin
    rd_mux = 32'd0;
    case (bus.address)
      3'd0:    rd_mux = shadow1;
      3'd1:    rd_mux = shadow2;
      3'd2:    rd_mux = shadow3;
      3'd3:    rd_mux = {29'd0, irq_flag, irq_en, pending};
      3'd4:    rd_mux = {16'd0, frame_cnt};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      shadow1      <= PARK_DESC;
      shadow2      <= PARK_DESC;
      shadow3      <= PARK_DESC;
      sprite1      <= PARK_DESC;
      sprite2      <= PARK_DESC;
      sprite3      <= PARK_DESC;
      irq_en       <= 1'b0;
      irq_flag     <= 1'b0;
      frame_cnt    <= 16'd0;
      vc_q         <= 10'd0;
      bus.readdata <= 32'd0;
    end else begin
      vc_q <= VGA_VCOUNT;

      if (rd_en) bus.readdata <= rd_mux;

      // Sprites sample the shadows before this edge's write lands.
      if (wr_en && (bus.address == 3'd0)) shadow1 <= bus.writedata;
      if (wr_en && (bus.address == 3'd1)) shadow2 <= bus.writedata;
      if (wr_en && (bus.address == 3'd2)) shadow3 <= bus.writedata;

      case (state)
        IDLE: begin
          if (wr_ctrl && bus.writedata[0]) state <= ARMED;
        end
        ARMED: begin
          if (vblank_start) begin
            state   <= IDLE;
            sprite1 <= shadow1;
            sprite2 <= shadow2;
            sprite3 <= shadow3;
          end
        end
        default: state <= IDLE;
      endcase

      if (wr_ctrl) irq_en <= bus.writedata[1];

      // A frame event beats a same-edge acknowledge so no interrupt is lost.
      if (vblank_start && irq_en) irq_flag <= 1'b1;
      else if (wr_frame)          irq_flag <= 1'b0;

      if (vblank_start) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sprite_desc_loader.sv
// Directed bench for sprite_desc_loader: a register-level model of the block
// is compared every cycle, with literal expectations pinning key scenarios.
module tb_sprite_desc_loader;
  localparam logic [31:0] PARK = 32'h000F_FFFF;

  logic        clk;
  logic        rst;
  logic [9:0]  vcount;
  logic [31:0] sprite1, sprite2, sprite3;
  logic        irq;

  sprite_desc_loader_if bus();

  sprite_desc_loader dut (
    .clk        (clk),
    .reset      (rst),
    .bus        (bus),
    .VGA_VCOUNT (vcount),
    .sprite1    (sprite1),
    .sprite2    (sprite2),
    .sprite3    (sprite3),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model of the register file and frame logic.
  logic [31:0] m_shadow [3];
  logic [31:0] m_active [3];
  logic [31:0] m_rdata;
  bit          m_pending, m_irq_en, m_irq_flag, m_valid;
  logic [15:0] m_frame;
  logic [9:0]  m_prev_vc;

  initial m_valid = 1'b0;

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0, 3'd1, 3'd2: return m_shadow[a[1:0]];
      3'd3:             return {29'd0, m_irq_flag, m_irq_en, m_pending};
      3'd4:             return {16'd0, m_frame};
      default:          return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model_upd
    bit vb, wr, rd, old_en;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        m_shadow[i] = PARK;
        m_active[i] = PARK;
      end
      m_pending  = 0;
      m_irq_en   = 0;
      m_irq_flag = 0;
      m_frame    = 16'd0;
      m_rdata    = 32'd0;
      m_prev_vc  = 10'd0;
      m_valid    = 1'b1;
    end else begin
      vb     = (vcount == 10'd480) && (m_prev_vc != 10'd480);
      wr     = bus.chipselect && bus.write;
      rd     = bus.chipselect && bus.read;
      old_en = m_irq_en;
      if (rd) m_rdata = model_read(bus.address);
      if (vb && m_pending) begin
        for (int i = 0; i < 3; i++) m_active[i] = m_shadow[i];
        m_pending = 0;
      end else if (wr && bus.address == 3'd3 && bus.writedata[0]) begin
        m_pending = 1;
      end
      if (wr && bus.address < 3'd3) m_shadow[bus.address[1:0]] = bus.writedata;
      if (vb && old_en)                     m_irq_flag = 1;
      else if (wr && bus.address == 3'd4)   m_irq_flag = 0;
      if (wr && bus.address == 3'd3) m_irq_en = bus.writedata[1];
      if (vb) m_frame = m_frame + 16'd1;
      m_prev_vc = vcount;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_sprite1", sprite1, m_active[0]);
      chk("cyc_sprite2", sprite2, m_active[1]);
      chk("cyc_sprite3", sprite3, m_active[2]);
      chk("cyc_irq", {31'd0, irq}, {31'd0, m_irq_flag && m_irq_en});
      chk("cyc_readdata", bus.readdata, m_rdata);
    end
  end

  task automatic bus_idle();
    bus.chipselect = 0;
    bus.write      = 0;
    bus.read       = 0;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1; bus.write = 1; bus.read = 0;
    bus.address = a; bus.writedata = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1; bus.read = 1; bus.write = 0;
    bus.address = a;
    @(negedge clk);
    bus_idle();
    d = bus.readdata;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd_reg(a, d);
    chk(name, d, exp);
  endtask

  task automatic vc_step(input logic [9:0] v);
    @(negedge clk);
    vcount = v;
  endtask

  // Brings the line to VBLANK_LINE while a write is presented on the same edge.
  task automatic wr_on_vblank(input logic [2:0] a, input logic [31:0] d);
    vc_step(10'd479);
    @(negedge clk);
    vcount = 10'd480;
    bus.chipselect = 1; bus.write = 1; bus.address = a; bus.writedata = d;
    @(negedge clk);
    bus_idle();
    vcount = 10'd481;
  endtask

  task automatic vblank_pulse();
    vc_step(10'd479);
    vc_step(10'd480);
    vc_step(10'd481);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0;
    vcount = 10'd0;
    bus.address = 3'd0;
    bus.writedata = 32'd0;
    bus_idle();

    // Accesses during reset must be ignored.
    repeat (2) @(negedge clk);
    wr_reg(3'd0, 32'hDEAD_BEEF);
    wr_reg(3'd3, 32'h0000_0003);
    @(negedge clk);
    rst = 1;

    rd_chk("rst_shadow0", 3'd0, PARK);
    rd_chk("rst_shadow1", 3'd1, PARK);
    rd_chk("rst_shadow2", 3'd2, PARK);
    rd_chk("rst_ctrl", 3'd3, 32'h0);
    rd_chk("rst_frame", 3'd4, 32'h0);
    rd_chk("unmapped5", 3'd5, 32'h0);
    chk("rst_sprite1", sprite1, PARK);
    chk("rst_sprite2", sprite2, PARK);
    chk("rst_sprite3", sprite3, PARK);

    // Full-frame sweep: commit lands exactly on the 479->480 edge.
    wr_reg(3'd0, 32'h4030_0C8A);
    wr_reg(3'd7, 32'h1234_5678);
    wr_reg(3'd3, 32'h0000_0001);
    rd_chk("armed_ctrl", 3'd3, 32'h1);
    for (int v = 0; v <= 524; v++) begin
      vc_step(v[9:0]);
      if (v == 480) chk("sweep_before_edge", sprite1, PARK);
      if (v == 481) chk("sweep_after_edge", sprite1, 32'h4030_0C8A);
    end
    rd_chk("sweep_ctrl", 3'd3, 32'h0);
    rd_chk("sweep_frame", 3'd4, 32'h1);

    // Shadow write on the commit edge: active gets the old shadow.
    wr_reg(3'd1, 32'h2222_2222);
    wr_reg(3'd3, 32'h0000_0001);
    wr_reg(3'd3, 32'h0000_0001);
    wr_on_vblank(3'd1, 32'h1111_1111);
    chk("same_edge_sprite2", sprite2, 32'h2222_2222);
    chk("same_edge_sprite1", sprite1, 32'h4030_0C8A);
    rd_chk("same_edge_shadow1", 3'd1, 32'h1111_1111);
    wr_reg(3'd3, 32'h0000_0001);
    vblank_pulse();
    chk("next_commit_sprite2", sprite2, 32'h1111_1111);

    // Commit request on a vblank edge while idle waits for the next vblank.
    wr_reg(3'd2, 32'h3333_3333);
    wr_on_vblank(3'd3, 32'h0000_0001);
    chk("late_arm_sprite3", sprite3, PARK);
    rd_chk("late_arm_ctrl", 3'd3, 32'h1);
    vblank_pulse();
    chk("late_arm_commit", sprite3, 32'h3333_3333);

    // Interrupt set/clear and precedence.
    wr_reg(3'd3, 32'h0000_0002);
    vblank_pulse();
    chk("irq_set", {31'd0, irq}, 32'h1);
    wr_on_vblank(3'd4, 32'h0);
    chk("irq_set_wins", {31'd0, irq}, 32'h1);
    wr_reg(3'd4, 32'h0);
    chk("irq_clear", {31'd0, irq}, 32'h0);
    vblank_pulse();
    chk("irq_reset_again", {31'd0, irq}, 32'h1);
    wr_reg(3'd3, 32'h0000_0000);
    chk("irq_masked", {31'd0, irq}, 32'h0);
    rd_chk("masked_ctrl", 3'd3, 32'h4);
    rd_chk("frame_8", 3'd4, 32'h8);

    // Frame counter wrap.
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    m_frame = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    rd_chk("frame_ffff", 3'd4, 32'h0000_FFFF);
    vblank_pulse();
    rd_chk("frame_wrap", 3'd4, 32'h0);

    // Reset while armed discards the commit.
    wr_reg(3'd3, 32'h0000_0001);
    rd_chk("pre_rst_ctrl", 3'd3, 32'h5);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    rd_chk("post_rst_ctrl", 3'd3, 32'h0);
    wr_reg(3'd0, 32'h5555_5555);
    vblank_pulse();
    chk("post_rst_sprite1", sprite1, PARK);
    chk("post_rst_sprite2", sprite2, PARK);
    chk("post_rst_sprite3", sprite3, PARK);
    rd_chk("post_rst_frame", 3'd4, 32'h1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
